regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Debug read-out engine for the single-cycle CPU `system`. It is the reading end of the register-file debug port (test_address_register / test_value_register).
- On a start pulse it steps the debug address through every architectural register and captures each 32-bit value.
- It streams the values as a framed byte sequence over a valid/ready byte interface, which feeds a UART transmitter or a bench monitor.
- It replaces manual per-register probing from the testbench.

Parameters:
- NUM_REGS, 32, number of registers scanned; addresses 0..NUM_REGS-1.
- ADDR_W, 5, width of debug register address.
- DATA_W, 32, register width; must be a multiple of 8.
- RD_LAT, 1, cycles waited after driving rd_addr before sampling rd_data (≥1).
- HDR_BYTE, 8'hA5, frame header value.

Ports:
- SYS_clk  in  1  system clock; all state updates on the rising edge.
- SYS_reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse after the checksum byte transfers.
- rd_addr  out  ADDR_W  drives the CPU's test_address_register.
- rd_data  in  DATA_W  from the CPU's test_value_register.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a transfer occurs when tx_valid && tx_ready on a rising edge.

Behaviour:
- Reset (async, SYS_reset_n=0):
  - State IDLE; busy=0, done=0, tx_valid=0, tx_data=0, rd_addr=0.
  - Register index, wait counter, byte index and checksum all cleared.
  - Reset asserted mid-frame aborts immediately; tx_valid drops without completing the handshake.
- Frame format (1 + NUM_REGS*(1+DATA_W/8) + 1 bytes; 162 at defaults):
  - HDR_BYTE.
  - For each reg i ascending: {3'b0, i[4:0]}, then data bytes MSB first.
  - CSUM = XOR of all bytes after the header.
- FSM states and transitions:
  - IDLE: start=1 → HDR. start is ignored in any other state.
  - HDR: tx_valid=1, tx_data=HDR_BYTE; on transfer → SETADDR with idx=0, csum=0.
  - SETADDR: rd_addr=idx; wait counter counts RD_LAT cycles → CAPTURE.
  - CAPTURE: latch rd_data into the shift register (1 cycle) → SEND with byte index 0.
    - rd_data is sampled exactly RD_LAT+1 cycles after rd_addr changes.
  - SEND: byte 0 = address byte, bytes 1..DATA_W/8 = data.
    - On each transfer, csum ^= byte and the byte index increments.
    - After the last data byte: if idx==NUM_REGS-1 → CSUM, else idx+1 → SETADDR.
  - CSUM: present csum; on transfer → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and the FSM does not advance.
  - tx_valid never deasserts without a transfer, except on reset.
  - With tx_ready held high, back-to-back bytes go out one per cycle.
  - A fresh tx_valid may rise in the same cycle tx_ready is already high.
- rd_addr holds its last value between registers and after the frame. It is reset to 0 only by reset or on entry to the next frame.
- Boundaries:
  - tx_ready stuck low → the FSM stalls indefinitely; no timeout.
  - idx wraps never: the terminal compare is against NUM_REGS-1.
  - start held high through a frame → one new frame starts only after DONE returns to IDLE.

Decomposition:
- Shared package `regdump_pkg`:
  - State encoding localparams (IDLE, HDR, SETADDR, CAPTURE, SEND, CSUM, DONE).
  - HDR_BYTE default.
  - Frame-length constant function.
- One natural sub-module: `byte_serializer`. It takes a DATA_W word plus a prefix byte and emits MSB-first bytes under valid/ready with a running XOR. The top FSM owns sequencing and the checksum byte.

Test Plan:
- Reset then idle: SYS_reset_n low 3 cycles → busy=0, tx_valid=0, rd_addr=0; start absent → no bytes for 50 cycles.
- Full dump, tx_ready=1, r8=32'h0000_0005, other regs 0:
  - 162 bytes arrive, starting A5 00 00 00 00 00 01 ...
  - Register 8 appears as 08 00 00 00 05.
  - CSUM = XOR of {00..1F} ^ 05 = 8'h05 (XOR of 0..31 is 0).
  - done pulses once; busy spans the frame.
- Backpressure: tx_ready toggled by a random pattern with 30% high → same 162-byte sequence; tx_data never changes while tx_valid && !tx_ready.
- Read latency: RD_LAT=2, bench model returns rd_data = {27'b0, rd_addr} valid only 2 cycles after an address change → every data word equals its address; no stale values.
- Start while busy: pulse start at byte 40 → ignored; exactly one done; a second start after done → second identical frame.
- Async reset mid-frame at byte 77 → tx_valid=0 immediately (before the next edge), busy=0; a subsequent start produces a complete correct frame from the header.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
package regdump_pkg;

    // Dump sequencer states; encoding is fixed so the debug output is stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_SETADDR = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Total bytes in one frame: header, (address byte + data bytes) per register, checksum.
    function automatic int frame_len(input int num_regs, input int data_w);
        return 2 + num_regs * (1 + data_w / 8);
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Byte-stream and register-file debug port bundle for the dump reader.
//
// Byte stream handshake: the master raises tx_valid with tx_data; a byte is
// transferred on any rising edge where tx_valid && tx_ready. Once raised,
// tx_valid and tx_data hold until that transfer (only reset may drop them).
// tx_ready may be high before tx_valid rises and does not depend on it.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output tx_data,
        output tx_valid,
        output rd_addr,
        input  tx_ready,
        input  rd_data
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  rd_addr,
        output tx_ready,
        output rd_data
    );
endinterface

// File: rtl/regfile_dump_reader_byte_serializer.sv
// Splits a prefix byte plus a data word into MSB-first bytes and keeps a
// running XOR of every byte handed off.
module byte_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [7:0]        i_prefix,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_xfer,
    input  logic              i_csum_clr,
    output logic [7:0]        o_byte,
    output logic              o_last,
    output logic [7:0]        o_csum
);
    localparam int NBYTES = DATA_W / 8;
    localparam int SH_W   = DATA_W + 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_csum;

    // Load prefix+word, then shift one byte out per transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= {i_prefix, i_word};
            r_cnt   <= '0;
        end else if (i_xfer) begin
            r_shift <= {r_shift[SH_W-9:0], 8'h00};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Running XOR over transferred bytes, cleared at the start of each frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= 8'h00;
        end else if (i_csum_clr) begin
            r_csum <= 8'h00;
        end else if (i_xfer) begin
            r_csum <= r_csum ^ o_byte;
        end
    end

    assign o_byte = r_shift[SH_W-1 -: 8];
    assign o_last = (r_cnt == CNT_W'(NBYTES));
    assign o_csum = r_csum;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the CPU register-file debug port and streams every register as a
// framed byte sequence: header, {address, data MSB first} per register, XOR.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5,
    parameter int         DATA_W   = 32,
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic                   SYS_clk,
    input  logic                   SYS_reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    regfile_dump_reader_if.master  bus,
    output state_t                 o_dbg_state
);
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [ADDR_W-1:0] r_rd_addr;

    logic       w_tx_valid;
    logic [7:0] w_tx_data;
    logic       w_xfer;
    logic       w_wait_done;
    logic       w_last_reg;
    logic [7:0] w_ser_byte;
    logic       w_ser_last;
    logic [7:0] w_ser_csum;
    logic       w_ser_xfer;
    logic       w_ser_load;
    logic       w_csum_clr;

    assign w_xfer      = w_tx_valid && bus.tx_ready;
    assign w_wait_done = (r_wait == WAIT_W'(RD_LAT - 1));
    assign w_last_reg  = (r_idx == ADDR_W'(NUM_REGS - 1));
    assign w_ser_xfer  = w_xfer && (r_state == ST_SEND);
    assign w_ser_load  = (r_state == ST_CAPTURE);
    assign w_csum_clr  = w_xfer && (r_state == ST_HDR);

    byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk      (SYS_clk),
        .i_rst_n    (SYS_reset_n),
        .i_load     (w_ser_load),
        .i_prefix   (8'(r_idx)),
        .i_word     (bus.rd_data),
        .i_xfer     (w_ser_xfer),
        .i_csum_clr (w_csum_clr),
        .o_byte     (w_ser_byte),
        .o_last     (w_ser_last),
        .o_csum     (w_ser_csum)
    );

    // State register.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and byte-stream outputs; a presented byte holds until it transfers.
    always_comb begin
        w_next_state = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        busy         = (r_state != ST_IDLE);
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_HDR;
            end
            ST_HDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = HDR_BYTE;
                if (bus.tx_ready) w_next_state = ST_SETADDR;
            end
            ST_SETADDR: begin
                if (w_wait_done) w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_ser_byte;
                if (bus.tx_ready && w_ser_last) begin
                    w_next_state = w_last_reg ? ST_CSUM : ST_SETADDR;
                end
            end
            ST_CSUM: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_ser_csum;
                if (bus.tx_ready) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Register index, debug address and read-latency wait counter.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_idx     <= '0;
            r_wait    <= '0;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        r_idx     <= '0;
                        r_rd_addr <= '0;
                        r_wait    <= '0;
                    end
                end
                ST_SETADDR: begin
                    if (!w_wait_done) r_wait <= r_wait + 1'b1;
                end
                ST_SEND: begin
                    if (w_xfer && w_ser_last && !w_last_reg) begin
                        r_idx     <= r_idx + 1'b1;
                        r_rd_addr <= r_idx + 1'b1;
                        r_wait    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.tx_data  = w_tx_data;
    assign bus.tx_valid = w_tx_valid;
    assign bus.rd_addr  = r_rd_addr;
    assign o_dbg_state  = r_state;

endmodule
